// File: rtl/serial_logic_unit.sv
// Multi-cycle AND/OR/XOR/NOR unit: one SLICE-bit slice per clock, LS slice first.
// Optional SERIAL_LOGIC_ZERO_FLAG_EN adds a registered zero flag on the completed result.

module slu_slice #(
  parameter int SLICE = 4
) (
  input  logic [1:0]       op_i,
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output logic [SLICE-1:0] y_o
);
  always_comb begin
    y_o = '0;
    case (op_i)
      2'b00:   y_o = a_i & b_i;
      2'b01:   y_o = a_i | b_i;
      2'b10:   y_o = a_i ^ b_i;
      default: y_o = ~(a_i | b_i);
    endcase
  end
endmodule

module serial_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, result_q, result_d;
  logic             busy_q, done_q;
  logic [SLICE-1:0] a_sl, b_sl, y_sl;
  logic             last;
  int               sl_lo;

  always_comb begin
    sl_lo = int'(cnt_q) * SLICE;
    a_sl  = a_q[sl_lo +: SLICE];
    b_sl  = b_q[sl_lo +: SLICE];
  end

  slu_slice #(.SLICE(SLICE)) u_slice (
    .op_i (op_q),
    .a_i  (a_sl),
    .b_i  (b_sl),
    .y_o  (y_sl)
  );

  // Only the active slice changes; the rest of result holds.
  always_comb begin
    result_d = result_q;
    result_d[sl_lo +: SLICE] = y_sl;
  end

  assign last = (cnt_q == CW'(NSLICE - 1));

`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
  logic acc_q, zero_q;
  assign zero = zero_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
      acc_q    <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // DONE accepts a new start exactly like IDLE for back-to-back issue.
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q  <= S_RUN;
            a_q      <= a;
            b_q      <= b;
            op_q     <= op;
            result_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
            acc_q    <= 1'b0;
            zero_q   <= 1'b0;
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          result_q <= result_d;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
          acc_q    <= acc_q | (|y_sl);
`endif
          if (last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
            zero_q  <= ~(acc_q | (|y_sl));
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Scoreboard bench for serial_logic_unit: expected words queued at issue, checked at done.
module tb_serial_logic_unit;
  localparam int WIDTH = 32;
  localparam int NS    = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             busy, done;
  logic [WIDTH-1:0] result;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
  logic             zero;
`endif

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  serial_logic_unit #(.WIDTH(WIDTH), .SLICE(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    ,
    .zero   (zero)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] model(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  // Called at a negedge; drives start for one edge and returns at the next negedge (cycle 1).
  task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered in cycle 'cyc'; returns at the negedge of the done cycle.
  task automatic wait_done(input string name, input int cyc);
    logic busy_bad = 1'b0;
    logic [WIDTH-1:0] e;
    int n = cyc;
    while (!done && n < 40) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
      if (zero !== 1'b0) busy_bad = 1'b1;
`endif
      @(negedge clk);
      n++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout: no done after %0d cycles", name, n);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    total++;
    if (n !== NS + 1) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, n, NS + 1);
    end
    total++;
    if (busy_bad || busy !== 1'b0) begin
      bad++; $display("FAIL %s busy/zero during run or busy at done", name);
    end
    e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    total++;
    if (result !== e) begin
      bad++; $display("FAIL %s result: got %h want %h", name, result, e);
    end
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    total++;
    if (zero !== (e == '0)) begin
      bad++; $display("FAIL %s zero: got %b want %b", name, zero, (e == '0));
    end
`endif
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      bad++; $display("FAIL reset: busy=%b done=%b result=%h want 0/0/0", busy, done, result);
    end
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    total++;
    if (zero !== 1'b0) begin bad++; $display("FAIL reset zero: got %b want 0", zero); end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_and;
    logic [WIDTH-1:0] hold;
    issue(2'b00, 32'hF0F0_1234, 32'hFF00_00FF);
    wait_done("and", 1);
    total++;
    if (result !== 32'hF000_0034) begin
      bad++; $display("FAIL and const: got %h want f0000034", result);
    end
    hold = result;
    repeat (3) @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== hold) begin
      bad++; $display("FAIL and hold: done=%b busy=%b result=%h want 0/0/%h", done, busy, result, hold);
    end
  endtask

  task automatic test_nor;
    issue(2'b11, 32'h0, 32'h0);
    wait_done("nor0", 1);
    @(negedge clk);
    issue(2'b11, 32'hFFFF_FFFF, 32'h0);
    wait_done("nor1", 1);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    issue(2'b10, 32'hAAAA_AAAA, 32'h5555_5555);
    wait_done("xor", 1);
    issue(2'b01, 32'h1, 32'h2);
    wait_done("b2b_or", 1);
    @(negedge clk);
  endtask

  task automatic test_ignored;
    int dn = 0;
    issue(2'b01, 32'h1, 32'h2);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 32'hFFFF_FFFF; op = 2'b11;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored", 4);
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    total++;
    if (dn !== 0) begin bad++; $display("FAIL ignored extra done: got %0d want 0", dn); end
  endtask

  task automatic test_reset_abort;
    int dn = 0;
    issue(2'b10, 32'h1234_5678, 32'h0F0F_0F0F);
    void'(exp_q.pop_back());
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      bad++; $display("FAIL abort: busy=%b done=%b result=%h want 0/0/0", busy, done, result);
    end
    repeat (15) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    total++;
    if (dn !== 0) begin bad++; $display("FAIL abort activity: got %0d cycles want 0", dn); end
  endtask

  task automatic test_slice_order;
    logic [63:0] mask;
    logic [WIDTH-1:0] av = 32'h8765_4321;
    issue(2'b01, av, 32'h0);
    for (int k = 1; k <= NS; k++) begin
      @(negedge clk);
      mask = (64'd1 << (4 * k)) - 64'd1;
      total++;
      if (result !== (av & mask[WIDTH-1:0])) begin
        bad++; $display("FAIL slice k=%0d: got %h want %h", k, result, av & mask[WIDTH-1:0]);
      end
    end
    total++;
    if (done !== 1'b1 || result !== exp_q[0]) begin
      bad++; $display("FAIL slice done: done=%b result=%h want 1/%h", done, result, exp_q[0]);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_and;
    test_nor;
    test_back_to_back;
    test_ignored;
    test_reset_abort;
    test_slice_order;
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1);
  end
endmodule
